// File: rtl/execute_stage.sv
// RV32I execute stage with the EX/MEM pipeline register.
// Define EX_FWD_EN to include the MEM/WB operand forwarding muxes.
module execute_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_m,
  input  logic            flush_m,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_ext_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc_plus4_e,
  input  logic [4:0]      rd_e,
  input  logic [2:0]      alu_control_e,
  input  logic            alu_src_e,
  input  logic            reg_write_e,
  input  logic            mem_write_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic [1:0]      result_src_e,
  input  logic [1:0]      forward_a_e,
  input  logic [1:0]      forward_b_e,
  input  logic [XLEN-1:0] result_w,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [4:0]      rd_m,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [1:0]      result_src_m
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;

`ifdef EX_FWD_EN
  // Operand sources: 10 = MEM-stage ALU result, 01 = writeback value, else register file.
  always_comb begin
    case (forward_a_e)
      2'b10:   src_a = alu_result_m;
      2'b01:   src_a = result_w;
      default: src_a = rd1_e;
    endcase
    case (forward_b_e)
      2'b10:   fwd_b = alu_result_m;
      2'b01:   fwd_b = result_w;
      default: fwd_b = rd2_e;
    endcase
  end
`else
  // Without forwarding the hazard unit stalls on every RAW dependency.
  logic unused_fwd;
  assign unused_fwd = ^{forward_a_e, forward_b_e, result_w};
  assign src_a      = rd1_e;
  assign fwd_b      = rd2_e;
`endif

  assign src_b = alu_src_e ? imm_ext_e : fwd_b;

  always_comb begin
    alu_result = '0;
    case (alu_control_e)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = XLEN'($signed(src_a) < $signed(src_b));
      default: alu_result = '0;
    endcase
  end

  // Redirect is never gated by stall/flush; the hazard unit owns suppression.
  assign zero        = (alu_result == '0);
  assign pc_src_e    = jump_e | (branch_e & zero);
  assign pc_target_e = pc_e + imm_ext_e;

  // EX/MEM register: reset > flush (bubble) > stall (hold) > load.
  always_ff @(posedge clk) begin
    if (reset || flush_m) begin
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= '0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
    end else if (!stall_m) begin
      alu_result_m <= alu_result;
      write_data_m <= fwd_b;
      pc_plus4_m   <= pc_plus4_e;
      rd_m         <= rd_e;
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      result_src_m <= result_src_e;
    end
  end

endmodule
